// File: rtl/block_byte_serializer_if.sv
// Bus bundle between the result-block producer, the serializer and the UART trigger.
// Handshake: a block moves on any cycle where valid_in is high and the block is accepted
// (ready_out high, or a pop frees the slot that same cycle); valid_out is a one-cycle
// trigger with no backpressure, issued only while request_next_byte_in is high.
interface block_byte_serializer_if #(
    parameter int REGISTER_SIZE = 32
);
    logic [REGISTER_SIZE-1:0] data_in;
    logic                     valid_in;
    logic                     ready_out;
    logic                     request_next_byte_in;
    logic [7:0]               data_out;
    logic                     valid_out;
    logic                     final_out;
    logic                     overflow_out;
    logic [1:0]               fsm_state;

    modport master (
        output data_in, valid_in, request_next_byte_in,
        input  ready_out, data_out, valid_out, final_out, overflow_out, fsm_state
    );

    modport slave (
        input  data_in, valid_in, request_next_byte_in,
        output ready_out, data_out, valid_out, final_out, overflow_out, fsm_state
    );
endinterface

// File: rtl/block_byte_serializer.sv
// Buffers REGISTER_SIZE-bit result blocks in a FIFO and emits them LSB byte first,
// paced by the UART idle signal, flagging the last byte of every BITS_IN_NUM-bit number.
module block_byte_serializer #(
    parameter int REGISTER_SIZE = 32,
    parameter int BITS_IN_NUM   = 4096,
    parameter int FIFO_DEPTH    = 16,
    parameter int GUARD_CYCLES  = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    block_byte_serializer_if.slave bus
);
    localparam int BYTES_PER_BLOCK = REGISTER_SIZE / 8;
    localparam int BYTES_PER_NUM   = BITS_IN_NUM / 8;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int BLW = $clog2(BYTES_PER_BLOCK + 1);
    localparam int NCW = (BYTES_PER_NUM > 1) ? $clog2(BYTES_PER_NUM) : 1;
    localparam int GCW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [AW:0]    FULL_COUNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [NCW-1:0] LAST_BYTE  = NCW'(BYTES_PER_NUM - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SEND, GUARD} state_t;
    state_t state, state_next;

    logic [REGISTER_SIZE-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [AW:0]              count, count_next;
    logic [REGISTER_SIZE-1:0] rd_data, sr;
    logic [BLW-1:0]           bytes_left;
    logic [NCW-1:0]           byte_cnt;
    logic [GCW-1:0]           guard_cnt;
    logic                     fifo_empty, guard_done, pop, push, fire;

    assign fifo_empty    = (count == '0);
    assign guard_done    = (guard_cnt == GCW'(GUARD_CYCLES - 1));
    // A pop in the same cycle makes room, so a write against a full FIFO still lands.
    assign push          = bus.valid_in && (bus.ready_out || pop);
    assign bus.fsm_state = state;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        fire       = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (bus.request_next_byte_in) begin
                    fire       = 1'b1;
                    state_next = GUARD;
                end
            end
            GUARD: begin
                if (guard_done) begin
                    if (bytes_left != '0) begin
                        state_next = SEND;
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        count_next = count;
        if (push && !pop)      count_next = count + 1'b1;
        else if (pop && !push) count_next = count - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr] <= bus.data_in;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            rd_data          <= '0;
            sr               <= '0;
            bytes_left       <= '0;
            byte_cnt         <= '0;
            guard_cnt        <= '0;
            bus.ready_out    <= 1'b1;
            bus.data_out     <= '0;
            bus.valid_out    <= 1'b0;
            bus.final_out    <= 1'b0;
            bus.overflow_out <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            count         <= count_next;
            bus.ready_out <= (count_next != FULL_COUNT);
            if (bus.valid_in && !push) bus.overflow_out <= 1'b1;

            bus.valid_out <= fire;
            bus.final_out <= fire && (byte_cnt == LAST_BYTE);
            if (state == LOAD) begin
                sr         <= rd_data;
                bytes_left <= BLW'(BYTES_PER_BLOCK);
            end else if (fire) begin
                bus.data_out <= sr[7:0];
                sr           <= sr >> 8;
                bytes_left   <= bytes_left - 1'b1;
                byte_cnt     <= (byte_cnt == LAST_BYTE) ? '0 : byte_cnt + 1'b1;
            end

            if (state == GUARD && !guard_done) guard_cnt <= guard_cnt + 1'b1;
            else                               guard_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_block_byte_serializer.sv
// Directed bench: three serializers (32-, 64- and 4096-bit numbers) share one clock and reset;
// byte triggers are captured per instance and compared against hand-built expected queues.
module tb_block_byte_serializer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_byte_serializer_if #(.REGISTER_SIZE(32)) if32 ();
    block_byte_serializer_if #(.REGISTER_SIZE(32)) if64 ();
    block_byte_serializer_if #(.REGISTER_SIZE(32)) if4k ();

    block_byte_serializer #(.BITS_IN_NUM(32))   u32 (.clk_in(clk), .rst_in(rst_n), .bus(if32));
    block_byte_serializer #(.BITS_IN_NUM(64))   u64 (.clk_in(clk), .rst_in(rst_n), .bus(if64));
    block_byte_serializer #(.BITS_IN_NUM(4096)) u4k (.clk_in(clk), .rst_in(rst_n), .bus(if4k));

    // UART model for the 64-bit instance: busy for 10 cycles after each trigger.
    int busy_cnt = 0;
    bit req64_at_edge = 1'b1;
    assign if64.request_next_byte_in = (busy_cnt == 0);
    always @(posedge clk) begin
        req64_at_edge <= if64.request_next_byte_in;
        if (if64.valid_out)    busy_cnt <= 10;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    logic [8:0] ev0[$], ev1[$], ev2[$];
    int         cy0[$];
    logic [8:0] exp_q[$];
    int         bad_final = 0;
    int         busy_viol = 0;

    always @(negedge clk) begin
        if (if32.valid_out) begin
            ev0.push_back({if32.final_out, if32.data_out});
            cy0.push_back(cyc);
        end
        if (if64.valid_out) ev1.push_back({if64.final_out, if64.data_out});
        if (if4k.valid_out) ev2.push_back({if4k.final_out, if4k.data_out});
        if (!if32.valid_out && if32.final_out) bad_final++;
        if (!if64.valid_out && if64.final_out) bad_final++;
        if (!if4k.valid_out && if4k.final_out) bad_final++;
        if (if64.valid_out && !req64_at_edge) busy_viol++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int ev_size(input int which);
        case (which)
            0:       return ev0.size();
            1:       return ev1.size();
            default: return ev2.size();
        endcase
    endfunction

    function automatic logic [8:0] pop_ev(input int which);
        if (ev_size(which) == 0) return 9'h1ff;
        case (which)
            0:       return ev0.pop_front();
            1:       return ev1.pop_front();
            default: return ev2.pop_front();
        endcase
    endfunction

    task automatic clear_all();
        ev0.delete(); ev1.delete(); ev2.delete(); cy0.delete(); exp_q.delete();
    endtask

    task automatic push_exp_block(input logic [31:0] w, input bit last_final);
        for (int b = 0; b < 4; b++)
            exp_q.push_back({last_final && (b == 3), w[8*b +: 8]});
    endtask

    task automatic wait_n(input int which, input int n, input int budget, input string tag);
        int k = 0;
        while (ev_size(which) < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        #1;
        check(tag, ev_size(which), n);
    endtask

    task automatic drain(input int which, input int n, input string tag);
        logic [8:0] got, exp;
        for (int k = 0; k < n; k++) begin
            got = pop_ev(which);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
            check($sformatf("%s[%0d]", tag, k), 32'(got), 32'(exp));
        end
    endtask

    task automatic push32(input logic [31:0] d, output int at);
        @(posedge clk); #1;
        if32.data_in  = d;
        if32.valid_in = 1'b1;
        @(posedge clk); #1;
        at            = cyc;
        if32.valid_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  push_cyc;
        int  i, guard;
        bit  saw_full;

        if32.valid_in = 1'b0; if32.data_in = '0; if32.request_next_byte_in = 1'b1;
        if64.valid_in = 1'b0; if64.data_in = '0;
        if4k.valid_in = 1'b0; if4k.data_in = '0; if4k.request_next_byte_in = 1'b1;

        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_data_out", if32.data_out, 0);
        check("rst_valid_out", if32.valid_out, 0);
        check("rst_final_out", if32.final_out, 0);
        check("rst_overflow", if4k.overflow_out, 0);
        check("rst_ready", if32.ready_out, 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_bytes", ev0.size() + ev1.size() + ev2.size(), 0);
        check("idle_ready", if4k.ready_out, 1);

        // Single block, request held high
        clear_all();
        push_exp_block(32'hA1B2C3D4, 1'b1);
        push32(32'hA1B2C3D4, push_cyc);
        wait_n(0, 4, 60, "single_count");
        if (cy0.size() > 0) check("single_first_latency", cy0[0] - push_cyc, 3);
        for (int k = 1; k < cy0.size(); k++)
            check($sformatf("single_spacing%0d", k), cy0[k] - cy0[k-1], 3);
        drain(0, 4, "single");

        // UART pacing, two blocks make one 64-bit number
        clear_all();
        push_exp_block(32'h00000001, 1'b0);
        push_exp_block(32'h80000000, 1'b1);
        @(posedge clk); #1;
        if64.data_in = 32'h00000001; if64.valid_in = 1'b1;
        @(posedge clk); #1;
        if64.data_in = 32'h80000000;
        @(posedge clk); #1;
        if64.valid_in = 1'b0;
        wait_n(1, 8, 400, "pace_count");
        drain(1, 8, "pace");

        // Full 4096-bit number, honouring ready_out
        clear_all();
        for (int b = 0; b < 128; b++) push_exp_block(32'(b), b == 127);
        i = 0; guard = 0; saw_full = 1'b0;
        while (i < 128 && guard < 10000) begin
            @(posedge clk); #1;
            if (!if4k.ready_out) begin
                saw_full      = 1'b1;
                if4k.valid_in = 1'b0;
            end else begin
                if4k.valid_in = 1'b1;
                if4k.data_in  = 32'(i);
                i++;
            end
            guard++;
        end
        @(posedge clk); #1;
        if4k.valid_in = 1'b0;
        check("full_blocks_sent", i, 128);
        check("full_ready_dropped", saw_full, 1);
        wait_n(2, 512, 8000, "full_count");
        drain(2, 512, "full");
        check("full_no_overflow", if4k.overflow_out, 0);

        // Overflow: one block sits in the shift register, 16 fill the FIFO, the 18th drops
        clear_all();
        if4k.request_next_byte_in = 1'b0;
        for (int b = 0; b < 17; b++) push_exp_block(32'h200 + 32'(b), 1'b0);
        @(posedge clk); #1;
        if4k.valid_in = 1'b1;
        for (int b = 0; b < 17; b++) begin
            if4k.data_in = 32'h200 + 32'(b);
            @(posedge clk); #1;
        end
        check("ovf_full_ready", if4k.ready_out, 0);
        check("ovf_not_yet", if4k.overflow_out, 0);
        if4k.data_in = 32'h0bad;
        @(posedge clk); #1;
        if4k.valid_in = 1'b0;
        check("ovf_set", if4k.overflow_out, 1);
        repeat (5) @(posedge clk);
        #1;
        check("ovf_held_no_bytes", ev2.size(), 0);
        if4k.request_next_byte_in = 1'b1;
        wait_n(2, 68, 2000, "ovf_count");
        drain(2, 68, "ovf");
        repeat (30) @(posedge clk);
        #1;
        check("ovf_no_extra", ev2.size(), 0);
        check("ovf_sticky", if4k.overflow_out, 1);

        // Async reset after the third byte of a number
        clear_all();
        push32(32'h11223344, push_cyc);
        wait_n(0, 3, 60, "areset_pre_count");
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_data_out", if32.data_out, 0);
        check("areset_valid_out", if32.valid_out, 0);
        check("areset_ready", if32.ready_out, 1);
        check("areset_ovf_cleared", if4k.overflow_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_all();
        repeat (20) @(posedge clk);
        #1;
        check("areset_no_flush", ev0.size(), 0);
        push_exp_block(32'hCAFEF00D, 1'b1);
        push32(32'hCAFEF00D, push_cyc);
        wait_n(0, 4, 60, "areset_post_count");
        drain(0, 4, "areset_post");

        check("final_only_with_valid", bad_final, 0);
        check("no_trigger_while_busy", busy_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
